// File: rtl/game_ctrl.sv
// game_ctrl: flap-bird game controller (IDLE/PLAY/DYING/OVER), bird physics, BCD score
// Ports:
//   i_clk          system clock, all state changes on rising edge
//   i_clr          asynchronous active-low reset
//   i_frame_tick   one-cycle pulse per video frame
//   i_btn_flap     synchronized, debounced flap button level
//   i_collide      bird/pipe overlap level
//   i_pipe_passed  one-cycle pulse when the bird clears a pipe
//   o_bird_y       bird top row, 0..Y_MAX
//   o_state        IDLE=0 PLAY=1 DYING=2 OVER=3
//   o_score        four packed BCD digits
//   o_scroll_en    high only in PLAY
//   o_game_over    high only in OVER
//   o_hiscore      best BCD score, present only when GAME_CTRL_HISCORE_EN is defined
module game_ctrl #(
  parameter int GRAVITY      = 1,
  parameter int FLAP_VEL     = -6,
  parameter int VMAX         = 8,
  parameter int Y_START      = 240,
  parameter int Y_MAX        = 464,
  parameter int DEATH_FRAMES = 60
) (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_frame_tick,
  input  logic        i_btn_flap,
  input  logic        i_collide,
  input  logic        i_pipe_passed,
  output logic [8:0]  o_bird_y,
  output logic [1:0]  o_state,
  output logic [15:0] o_score,
  output logic        o_scroll_en,
  output logic        o_game_over
`ifdef GAME_CTRL_HISCORE_EN
  ,
  output logic [15:0] o_hiscore
`endif
);
  localparam int DW = $clog2(DEATH_FRAMES + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_DYING = 2'd2, S_OVER = 2'd3;

  logic [1:0]        r_state, w_state_nxt;
  logic              r_btn_prev, r_armed, r_flap;
  logic signed [5:0] r_vel;
  logic [8:0]        r_y;
  logic [15:0]       r_score;
  logic [DW-1:0]     r_dcnt;
  logic              w_press, w_floor, w_dcnt_done;
  logic signed [6:0] w_vel_sum;
  logic signed [5:0] w_vel_grav, w_vel_nxt;
  logic signed [10:0] w_y_sum;
  logic [8:0]        w_y_sat;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (c) begin
        r[k*4+:4] = (v[k*4+:4] == 4'd9) ? 4'd0 : v[k*4+:4] + 4'd1;
        c = v[k*4+:4] == 4'd9;
      end
    end
    return (v == 16'h9999) ? v : r;
  endfunction

  // r_armed blocks a button held through reset release from reading as a press
  assign w_press     = r_armed & i_btn_flap & ~r_btn_prev;
  assign w_vel_sum   = 7'(r_vel) + 7'(GRAVITY);
  assign w_vel_grav  = (w_vel_sum > 7'(VMAX)) ? 6'(VMAX) : 6'(w_vel_sum);
  assign w_vel_nxt   = (r_state == S_PLAY && (r_flap || w_press)) ? 6'(FLAP_VEL) : w_vel_grav;
  // 11-bit signed sum so both underflow and overflow are visible before clamping
  assign w_y_sum     = $signed({2'b00, r_y}) + 11'(w_vel_nxt);
  assign w_y_sat     = w_y_sum[10] ? 9'd0 : (w_y_sum > 11'(Y_MAX)) ? 9'(Y_MAX) : w_y_sum[8:0];
  assign w_floor     = w_y_sat == 9'(Y_MAX);
  assign w_dcnt_done = r_dcnt == DW'(DEATH_FRAMES - 1);

  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_press ? S_PLAY : S_IDLE;
      S_PLAY:  w_state_nxt = (i_frame_tick && (i_collide || w_floor)) ? S_DYING : S_PLAY;
      S_DYING: w_state_nxt = (i_frame_tick && (w_floor || w_dcnt_done)) ? S_OVER : S_DYING;
      default: w_state_nxt = w_press ? S_IDLE : S_OVER;
    endcase
  end

  always_comb begin
    o_scroll_en = r_state == S_PLAY;
    o_game_over = r_state == S_OVER;
  end

  assign o_state  = r_state;
  assign o_bird_y = r_y;
  assign o_score  = r_score;

  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_btn_prev <= 1'b0;
      r_armed    <= 1'b0;
      r_flap     <= 1'b0;
      r_vel      <= '0;
      r_y        <= 9'(Y_START);
      r_score    <= '0;
      r_dcnt     <= '0;
    end else begin
      r_btn_prev <= i_btn_flap;
      r_armed    <= 1'b1;
      r_dcnt     <= '0;
      case (r_state)
        S_IDLE: begin
          r_y   <= 9'(Y_START);
          r_vel <= '0;
          if (w_press) begin
            r_score <= '0;
            r_flap  <= 1'b1;
          end
        end
        S_PLAY: begin
          if (i_frame_tick) begin
            r_vel  <= w_vel_nxt;
            r_y    <= w_y_sat;
            r_flap <= 1'b0;
          end else if (w_press) r_flap <= 1'b1;
          if (i_pipe_passed) r_score <= bcd_inc(r_score);
        end
        S_DYING: begin
          r_dcnt <= r_dcnt + DW'(i_frame_tick);
          if (i_frame_tick) begin
            r_vel <= w_vel_nxt;
            r_y   <= w_y_sat;
          end
        end
        default: begin
          if (w_press) begin
            r_y   <= 9'(Y_START);
            r_vel <= '0;
          end
        end
      endcase
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic [15:0] r_hiscore;
  // packed BCD orders the same as binary, so a plain compare suffices
  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) r_hiscore <= '0;
    else if (r_state == S_DYING && w_state_nxt == S_OVER && r_score > r_hiscore) r_hiscore <= r_score;
  end
  assign o_hiscore = r_hiscore;
`endif
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter GRAVITY, default 1, signed velocity increment per frame (px/frame²).
REQ-002 Parameter FLAP_VEL, default -6, signed velocity loaded on flap.
REQ-003 Parameter VMAX, default 8, positive fall-speed limit.
REQ-004 Parameter Y_START, default 240, bird_y in IDLE.
REQ-005 Parameter Y_MAX, default 464, floor (lowest legal bird_y).
REQ-006 Parameter DEATH_FRAMES, default 60, max frames spent in DYING.
REQ-007 clk  in  1  system clock; all state changes on its rising edge.
REQ-008 clr  in  1  reset, asynchronous, active-low.
REQ-009 frame_tick  in  1  one-cycle pulse per video frame.
REQ-010 btn_flap  in  1  synchronized, debounced flap button level.
REQ-011 collide  in  1  bird/pipe overlap level from renderer.
REQ-012 pipe_passed  in  1  one-cycle pulse when bird clears a pipe.
REQ-013 bird_y  out  9  bird top row, 0..Y_MAX.
REQ-014 state  out  2  IDLE=0, PLAY=1, DYING=2, OVER=3.
REQ-015 score  out  16  four packed BCD digits, [15:12] most significant.
REQ-016 scroll_en  out  1  pipes scroll; high only in PLAY.
REQ-017 game_over  out  1  high only in OVER.

Function
REQ-018 Press = rising edge of btn_flap (registered previous value); one press per edge regardless of hold length.
REQ-019 IDLE: bird_y=Y_START, vel=0; press -> PLAY next cycle, score cleared to 0, flap_pending set.
REQ-020 PLAY, press: flap_pending set; multiple presses before next frame_tick collapse to one.
REQ-021 PLAY, frame_tick: vel_next = FLAP_VEL if flap_pending else min(vel+GRAVITY, VMAX); flap_pending cleared; bird_y = saturate(bird_y + vel_next, 0, Y_MAX); update completes in the same clock as frame_tick (1-cycle latency).
REQ-022 vel held as 6-bit signed; arithmetic on bird_y done at 11 bits signed before saturation; no wrap-around.
REQ-023 PLAY -> DYING on frame_tick when collide=1 or the saturated bird_y equals Y_MAX; position update of that frame still applied.
REQ-024 pipe_passed counted only in a cycle where state=PLAY, including the cycle of a PLAY->DYING transition; ignored in all other states.
REQ-025 Score increments in BCD with digit carry; saturates at 9999 (no wrap to 0000).
REQ-026 DYING: flap ignored; each frame_tick applies gravity-only update (REQ-021 without flap), frame counter increments; -> OVER on frame_tick when bird_y reaches Y_MAX or counter reaches DEATH_FRAMES.
REQ-027 OVER: bird_y and score frozen; press -> IDLE next cycle (bird_y=Y_START, vel=0, score retained until next IDLE->PLAY).
REQ-028 collide while in IDLE or OVER has no effect; press coincident with frame_tick in PLAY is applied on that frame.

Reset
REQ-029 clr=0 forces immediately, independent of clk: state=IDLE, bird_y=Y_START, vel=0, score=0, flap_pending=0, death counter=0, edge-detect register=0, scroll_en=0, game_over=0.
REQ-030 Reset asserted mid-game discards all progress; first press after release starts a new game (button held through release is not a press).

Configuration
REQ-031 Macro GAME_CTRL_HISCORE_EN defined: extra output hiscore (out, 16, BCD), reset to 0, loaded with score on entry to OVER when score > hiscore (BCD compare), otherwise unchanged.
REQ-032 Macro undefined: no hiscore port or register; all other behaviour identical.

Verification
REQ-033 Release reset, press, 3 frame_ticks no press -> state=1, vel -6,-5,-4, bird_y 234,229,225.
REQ-034 PLAY, 10 pipe_passed pulses starting at score 0x0995 -> score 0x1005; from 0x9998 two pulses -> 0x9999.
REQ-035 PLAY, collide=1 with pipe_passed on the same frame_tick cycle -> score +1, state=2, scroll_en=0.
REQ-036 DYING from bird_y=100 with vel=0 -> state=3 after ticks until bird_y=464 or 60 ticks, whichever first; game_over=1.
REQ-037 OVER, press -> IDLE, bird_y=240, score held; press -> PLAY, score=0x0000; with GAME_CTRL_HISCORE_EN, hiscore equals prior game score.
REQ-038 clr pulsed low mid-PLAY between clk edges -> outputs at reset values before next clk edge; held button yields no start.
